// File: rtl/iq_pkg.sv
// Shared definitions for the IQ deserializer: word width, pairing FSM state
// encoding and the sample sign-extension helper.
package iq_pkg;

   localparam int IQ_WORD_W = 32;

   // Pairing FSM state; plain logic constants keep older tools happy.
   typedef logic [0:0] iq_state_t;
   localparam iq_state_t S_I = 1'b0;
   localparam iq_state_t S_Q = 1'b1;

   // Sign-extend the low w bits of raw (w in 8..16) to a full 16-bit value.
   function automatic logic [15:0] sign_ext16(input logic [15:0] raw, input int w);
      logic [15:0] t;
      t = raw << (16 - w);
      return 16'($signed(t) >>> (16 - w));
   endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock show-ahead FIFO for packed IQ words. The head word is driven
// combinationally, so the consumer samples rd_data in the same cycle it pops.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module iq_sync_fifo
   import iq_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [IQ_WORD_W-1:0] wr_data,
   input  logic                 rd_en,
   output logic [IQ_WORD_W-1:0] rd_data,
   output logic                 rd_dr,
   output logic                 full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]          wr_ptr_q, wr_ptr_d;
   logic [AW:0]          rd_ptr_q, rd_ptr_d;
   logic [IQ_WORD_W-1:0] mem_q [DEPTH];
   logic                 empty, do_rd, do_wr;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   assign rd_dr   = ~empty;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Next-pointer computation; pointers wrap naturally modulo 2*DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents are don't-care while empty, so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/iq_deserializer.sv
// Pairs interleaved I/Q ADC samples into 32-bit {I,Q} words and queues them
// for the packetizer. Words that arrive while the queue is full (and not being
// popped) are dropped and counted.
// Optional build macro IQ_TEST_PATTERN_EN adds tp_sel, which substitutes a
// ramp pattern {ramp, ~ramp} for each formed word.
module iq_deserializer
   import iq_pkg::*;
#(
   parameter int SAMPLE_W = 12,
   parameter int DEPTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SAMPLE_W-1:0]  adc_data,
   input  logic                 adc_frame,
   input  logic                 adc_valid,
   input  logic                 rd_en,
`ifdef IQ_TEST_PATTERN_EN
   input  logic                 tp_sel,
`endif
   output logic [IQ_WORD_W-1:0] rd_data,
   output logic                 rd_dr,
   output logic                 overflow,
   output logic [15:0]          drop_count
);

   iq_state_t            state_q, state_d;
   logic [15:0]          i_q, i_d;
   logic [IQ_WORD_W-1:0] word_q, word_d;
   logic                 push_q, push_d;
   logic                 overflow_q, overflow_d;
   logic [15:0]          drop_count_q, drop_count_d;
   logic [15:0]          sample_sx;
   logic                 fifo_full, drop;
`ifdef IQ_TEST_PATTERN_EN
   logic [15:0]          ramp_q, ramp_d;
`endif

   assign sample_sx = sign_ext16(16'(adc_data), SAMPLE_W);

   // Pairing: latch I, then a following Q forms a word that is pushed one
   // cycle later through push_q/word_q. A repeated I overwrites the latch.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      word_d  = word_q;
      push_d  = 1'b0;
`ifdef IQ_TEST_PATTERN_EN
      ramp_d  = ramp_q;
`endif
      if (adc_valid) begin
         case (state_q)
            S_I: begin
               if (adc_frame) begin
                  i_d     = sample_sx;
                  state_d = S_Q;
               end
            end
            default: begin
               if (adc_frame) begin
                  i_d = sample_sx;
               end else begin
                  word_d  = {i_q, sample_sx};
                  push_d  = 1'b1;
                  state_d = S_I;
`ifdef IQ_TEST_PATTERN_EN
                  if (tp_sel) word_d = {ramp_q, ~ramp_q};
                  ramp_d = ramp_q + 16'd1;
`endif
               end
            end
         endcase
      end
   end

   // Drop accounting: a full queue only absorbs a push when it is also popped.
   assign drop = push_q & fifo_full & ~rd_en;

   always_comb begin
      overflow_d   = overflow_q | drop;
      drop_count_d = drop_count_q;
      if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
   end

   // Pairing, pending-push and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_I;
         i_q          <= '0;
         word_q       <= '0;
         push_q       <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         word_q       <= word_d;
         push_q       <= push_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

`ifdef IQ_TEST_PATTERN_EN
   // Test-pattern ramp, advanced once per formed word.
   always_ff @(posedge clk) begin
      if (rst) ramp_q <= '0;
      else     ramp_q <= ramp_d;
   end
`endif

   iq_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (push_q),
      .wr_data(word_q),
      .rd_en  (rd_en),
      .rd_data(rd_data),
      .rd_dr  (rd_dr),
      .full   (fifo_full)
   );

   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_iq_deserializer.sv
// Self-checking bench for iq_deserializer: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a queue model.
module tb_iq_deserializer;

   localparam int SW    = 12;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [SW-1:0] adc_data = '0;
   logic          adc_frame = 1'b0;
   logic          adc_valid = 1'b0;
   logic          rd_en = 1'b0;
`ifdef IQ_TEST_PATTERN_EN
   logic          tp_sel = 1'b0;
`endif
   logic [31:0]   rd_data;
   logic          rd_dr;
   logic          overflow;
   logic [15:0]   drop_count;

   int errors = 0;
   int checks = 0;

   iq_deserializer #(.SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .adc_data  (adc_data),
      .adc_frame (adc_frame),
      .adc_valid (adc_valid),
      .rd_en     (rd_en),
`ifdef IQ_TEST_PATTERN_EN
      .tp_sel    (tp_sel),
`endif
      .rd_data   (rd_data),
      .rd_dr     (rd_dr),
      .overflow  (overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] mq[$];
   bit          have_i = 0;
   logic [15:0] i_val = '0;
   bit          pend_v = 0;
   logic [31:0] pend_w = '0;
   logic [15:0] ramp_m = '0;
   bit          ovf_m = 0;
   int          drops_m = 0;

   function automatic logic [15:0] sx(input logic [SW-1:0] s);
      int v;
      v = int'(s);
      if (v >= (1 << (SW - 1))) v = v - (1 << SW);
      return 16'(v);
   endfunction

   task automatic model_step();
      bit pop_ok, push_ok;
      if (rst) begin
         mq.delete();
         have_i = 0; i_val = '0; pend_v = 0; ramp_m = '0; ovf_m = 0; drops_m = 0;
         return;
      end
      pop_ok  = rd_en && (mq.size() > 0);
      push_ok = 0;
      if (pend_v) begin
         if (mq.size() == DEPTH && !rd_en) begin
            ovf_m = 1;
            if (drops_m < 65535) drops_m++;
         end else push_ok = 1;
      end
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(pend_w);
      pend_v = 0;
      if (adc_valid) begin
         if (adc_frame) begin
            i_val = sx(adc_data);
            have_i = 1;
         end else if (have_i) begin
            pend_w = {i_val, sx(adc_data)};
`ifdef IQ_TEST_PATTERN_EN
            if (tp_sel) pend_w = {ramp_m, ~ramp_m};
`endif
            ramp_m = ramp_m + 16'd1;
            pend_v = 1;
            have_i = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      chk("m_rd_dr", 32'(rd_dr), 32'(mq.size() > 0));
      chk("m_rd_data", rd_data, (mq.size() > 0) ? mq[0] : 32'h0);
      chk("m_overflow", 32'(overflow), 32'(ovf_m));
      chk("m_drop_count", 32'(drop_count), 32'(drops_m));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic v, input logic f, input logic [SW-1:0] d, input logic r);
      adc_valid = v; adc_frame = f; adc_data = d; rd_en = r;
      @(posedge clk); #1;
   endtask

   task automatic pair(input logic [SW-1:0] i, input logic [SW-1:0] q);
      cyc(1, 1, i, 0);
      cyc(1, 0, q, 0);
   endtask

   task automatic do_reset();
      rst = 1;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      rst = 0;
   endtask

   task automatic drain(output int n);
      n = 0;
      while (rd_dr && n < 4 * DEPTH) begin
         n++;
         cyc(0, 0, 0, 1);
      end
   endtask

   int n;
   logic [31:0] last_w;

   initial begin
      // Reset state
      do_reset();
      chk("rst_rd_dr", 32'(rd_dr), 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_drop_count", 32'(drop_count), 0);

      // Extreme values and latency
      cyc(1, 1, 12'h7FF, 0);
      cyc(1, 0, 12'h800, 0);
      chk("lat_not_yet", 32'(rd_dr), 0);
      cyc(0, 0, 0, 0);
      chk("ext_rd_dr", 32'(rd_dr), 1);
      chk("ext_word", rd_data, 32'h07FF_F800);
      drain(n);
      chk("ext_count", n, 1);

      // Resync and stray Q
      do_reset();
      cyc(1, 0, 12'd7, 0);
      cyc(0, 0, 0, 0);
      chk("stray_q", 32'(rd_dr), 0);
      cyc(1, 1, 12'd1, 0);
      cyc(1, 1, 12'd5, 0);
      cyc(1, 0, 12'd3, 0);
      cyc(0, 0, 0, 0);
      chk("resync_word", rd_data, 32'h0005_0003);
      cyc(0, 0, 0, 1);
      chk("resync_one", 32'(rd_dr), 0);

      // Overflow: 17 words into a 16-deep queue
      do_reset();
      for (int k = 0; k < 17; k++) pair(12'(3 * k), 12'hF00 | 12'(k));
      cyc(0, 0, 0, 0);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_drops", 32'(drop_count), 1);
      for (int k = 0; k < 16; k++) begin
         chk("ovf_order", rd_data, {16'(3 * k), 16'hFF00 | 16'(k)});
         cyc(0, 0, 0, 1);
      end
      chk("ovf_empty", 32'(rd_dr), 0);
      chk("ovf_empty_data", rd_data, 0);

      // Full with simultaneous push and pop
      do_reset();
      for (int k = 0; k < 16; k++) pair(12'(k), 12'(k + 1));
      cyc(0, 0, 0, 0);
      cyc(1, 1, 12'h0AA, 0);
      cyc(1, 0, 12'h055, 0);
      cyc(0, 0, 0, 1);
      chk("full_pp_drops", 32'(drop_count), 0);
      chk("full_pp_ovf", 32'(overflow), 0);
      n = 0; last_w = '0;
      while (rd_dr && n < 4 * DEPTH) begin
         n++; last_w = rd_data;
         cyc(0, 0, 0, 1);
      end
      chk("full_pp_occ", n, 16);
      chk("full_pp_last", last_w, 32'h00AA_0055);

      // Reset mid-pair, then push+pop on empty
      do_reset();
      cyc(1, 1, 12'd9, 0);
      rst = 1;
      cyc(0, 0, 0, 0);
      rst = 0;
      cyc(1, 0, 12'd1, 0);
      cyc(0, 0, 0, 0);
      chk("midrst_empty", 32'(rd_dr), 0);
      pair(12'd2, 12'd4);
      cyc(0, 0, 0, 1);
      chk("midrst_dr", 32'(rd_dr), 1);
      chk("midrst_word", rd_data, 32'h0002_0004);
      cyc(0, 0, 0, 1);

`ifdef IQ_TEST_PATTERN_EN
      // Test pattern ramp
      do_reset();
      tp_sel = 1;
      for (int k = 0; k < 3; k++) pair(12'h123, 12'h456);
      cyc(0, 0, 0, 0);
      tp_sel = 0;
      chk("tp_w0", rd_data, 32'h0000_FFFF); cyc(0, 0, 0, 1);
      chk("tp_w1", rd_data, 32'h0001_FFFE); cyc(0, 0, 0, 1);
      chk("tp_w2", rd_data, 32'h0002_FFFD); cyc(0, 0, 0, 1);
`endif

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         int rd_pct;
         case ((k / 250) % 3)
            0: rd_pct = 10;
            1: rd_pct = 50;
            default: rd_pct = 90;
         endcase
`ifdef IQ_TEST_PATTERN_EN
         if (k % 250 == 0) tp_sel = $urandom_range(0, 1) != 0;
`endif
         rst = ($urandom_range(0, 399) == 0);
         cyc($urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 5,
             SW'($urandom),
             $urandom_range(0, 99) < rd_pct);
      end
      rst = 0;
      cyc(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iq_deserializer.md
IQ_DESERIALIZER -- requirements
Module: iq_deserializer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 12: ADC sample width in bits, legal range 8..16.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO depth in 32-bit words, power of two, at least 4.
REQ-003 clk  input  1  Clock; the sole clock, shared with the downstream packetizer.
REQ-004 rst  input  1  Reset; synchronous, active-high.
REQ-005 adc_data  input  SAMPLE_W  Interleaved two's-complement I/Q sample.
REQ-006 adc_frame  input  1  High marks an I sample; low marks a Q sample.
REQ-007 adc_valid  input  1  adc_data and adc_frame are valid this cycle.
REQ-008 rd_en  input  1  Pop request from the packetizer.
REQ-009 rd_data  output  32  Head word {I[15:0],Q[15:0]}, show-ahead.
REQ-010 rd_dr  output  1  FIFO non-empty; rd_data is valid.
REQ-011 overflow  output  1  Sticky flag: at least one word has been dropped.
REQ-012 drop_count  output  16  Count of dropped words, saturating.

Function
REQ-013 Pairing FSM SHALL have two states, S_I and S_Q; the reset state is S_I.
REQ-014 In S_I, adc_valid&adc_frame SHALL latch I and move to S_Q; adc_valid&~adc_frame SHALL be discarded and the FSM SHALL stay in S_I.
REQ-015 In S_Q, adc_valid&~adc_frame SHALL form a word, push it, and move to S_I.
REQ-016 In S_Q, adc_valid&adc_frame (resync) SHALL overwrite the latched I and stay in S_Q, with no push.
REQ-017 I and Q SHALL each be sign-extended from SAMPLE_W to 16 bits; I SHALL occupy [31:16] and Q [15:0].
REQ-018 Latency SHALL be: Q accepted at edge N, word visible on rd_data with rd_dr=1 after edge N+1.
REQ-019 rd_data SHALL be first-word-fall-through: the consumer samples rd_data in the same cycle it asserts rd_en, and the next word appears after that edge.
REQ-020 rd_en while empty SHALL be ignored, with no pointer change and no error.
REQ-021 A push while full and not popping SHALL be dropped, set overflow, and increment drop_count, saturating at 16'hFFFF.
REQ-022 Simultaneous push and pop when full SHALL accept both, leaving occupancy unchanged with no drop.
REQ-023 Simultaneous push and pop when empty SHALL apply the push only; the pop is ignored and rd_dr rises next cycle.
REQ-024 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal.
REQ-025 rd_data SHALL be 0 when empty.

Reset
REQ-026 rst SHALL force: FSM=S_I, FIFO empty, rd_dr=0, rd_data=0, overflow=0, drop_count=0, latched I=0.
REQ-027 rst asserted mid-pair SHALL discard the half-formed pair; the first valid after rst release SHALL be treated per REQ-014.
REQ-028 rst SHALL take precedence over simultaneous push and pop.

Configuration
REQ-029 Macro IQ_TEST_PATTERN_EN SHALL compile in a test source; without it, only the ADC path exists.
REQ-030 With IQ_TEST_PATTERN_EN defined, the input port tp_sel (1 bit) SHALL exist; when tp_sel=1, each formed word SHALL be replaced by {ramp[15:0], ~ramp[15:0]}, where ramp starts at 0 after reset and increments once per push attempt. Pairing timing is unchanged.
REQ-031 With IQ_TEST_PATTERN_EN defined and tp_sel=0, behaviour SHALL be identical to the build without the macro.

Structure
REQ-032 A shared package iq_pkg SHALL hold the IQ_WORD_W=32 constant, the FSM state typedef, and the sign-extension function.
REQ-033 FIFO storage and pointers SHALL be the sub-module iq_sync_fifo (show-ahead, parameter DEPTH); pairing, the test pattern and the counters SHALL live in the top level.

Verification
REQ-034 I=12'h7FF, Q=12'h800 on consecutive valids -> rd_data=32'h07FF_F800 and rd_dr=1, two edges after Q.
REQ-035 Sequence I(1), I(5), Q(3) -> exactly one word, 32'h0005_0003; stray Q in S_I -> no word.
REQ-036 DEPTH=16; push 17 words with rd_en=0 -> 16 stored, overflow=1, drop_count=1; the read order matches the first 16.
REQ-037 FIFO full with simultaneous push and pop -> drop_count unchanged, occupancy stays 16.
REQ-038 rst asserted between I and Q -> rd_dr=0 and no word; next pair I(2), Q(4) -> 32'h0002_0004.
REQ-039 With IQ_TEST_PATTERN_EN and tp_sel=1, three pairs -> 32'h0000_FFFF, 32'h0001_FFFE, 32'h0002_FFFD.
